approx_mult_pipe: RTL and testbench
===================================

# approx_mult_pipe

- Pipelined, parametrised unsigned approximate multiplier; next generation of the fixed 8x8 truncated/OR-compensated multipliers.
- Width and truncation depth are parameters; approximation mode is selectable per transaction.
- Valid/ready handshake on both sides, so it drops into streaming datapaths and error-characterisation benches without external glue.
- Optional statistics block accumulates error against the exact product.

## Interface
- WIDTH, 8, operand width (≥4).
- L, 4, number of low x rows (x[L-1:0]) subject to approximation (1 ≤ L < WIDTH).
- CNT_W, 32, width of statistics counters.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block accepts operands this cycle.
- x, y  in  WIDTH  unsigned operands.
- mode  in  2  0 exact, 1 truncate, 2 OR-compensated, 3 count-compensated.
- out_valid  out  1  z valid.
- out_ready  in  1  consumer accepts z.
- z  out  2*WIDTH  approximate product.
- txn_count  out  CNT_W  accepted-result count (STATS_EN only).
- err_sum  out  CNT_W  accumulated (exact − z) (STATS_EN only).

## Operation
- Let P_hi = y * x[WIDTH-1:L] << L. Dropped bits: b(i,j) = x[i] & y[j] for i < L.
- Mode 0: z = x * y.
- Mode 1: z = P_hi.
- Mode 2: z = P_hi + Σ over columns c ≥ WIDTH of (OR of all b(i,j) with i+j = c) << c.
- Mode 3: z = P_hi + Σ over columns c ≥ WIDTH of (popcount of b(i,j) with i+j = c) << c.
- Bits with i+j < WIDTH are always discarded in modes 1–3.
- Invariants: z ≤ x*y in all modes; no overflow of 2*WIDTH bits.
- Stats, when compiled in, update on each output handshake:
  - txn_count += 1.
  - err_sum += (x*y − z).
  - Both saturate at all-ones and hold there.

## Timing
- Two register stages:
  - S1 latches x, y, mode and the generated partial rows.
  - S2 latches the final sum and out_valid.
- Latency 2 cycles from in handshake to out_valid.
- Throughput 1 per cycle when out_ready = 1.
- Advance enable: adv = !out_valid || out_ready. Define in_ready = adv.
  - Both stages shift only when adv = 1.
  - A bubble in S1 propagates as out_valid = 0.
- Stall (out_valid = 1, out_ready = 0): z, out_valid and S1 contents hold stable; in_ready = 0.
- Simultaneous out handshake and in handshake: allowed; no bubble is inserted.
- Stats update only in the cycle where out_valid && out_ready.
- Reset values:
  - in_ready 1.
  - out_valid 0, z 0, S1 valid 0.
  - txn_count 0, err_sum 0.
- Reset mid-stream discards both in-flight transactions; no out_valid follows.
- mode is sampled with the operands; changing mode mid-stream affects only later transactions.

## Configuration
- STATS_EN defined:
  - An exact product is carried alongside through S1/S2.
  - txn_count and err_sum are driven as specified.
- STATS_EN undefined:
  - No exact-product datapath and no counters.
  - txn_count and err_sum are tied to 0.
  - Latency and handshake are unchanged.

## Structure
- Package approx_mult_pkg:
  - mode enum (MODE_EXACT, MODE_TRUNC, MODE_OR, MODE_CNT).
  - Default WIDTH, L, CNT_W constants.
  - Function returning the saturating add.
- Sub-module approx_pp_gen:
  - Combinational; parameters WIDTH, L.
  - Produces P_hi, the per-column OR vector and the per-column popcount vector for columns WIDTH..2*WIDTH-2.
  - Its outputs feed S1.
- Top level holds the pipeline registers, handshake, final mode mux/adder and stats.

## Test plan
- WIDTH=8, L=4, x=0xFF, y=0xFF, out_ready=1, modes 0/1/2/3 back-to-back → z = 65025 / 61200 / 62992 / 64016 on four consecutive cycles starting 2 cycles after first accept.
- x=0x0F, y=0xFF → mode1 z=0; mode2 z=1792; mode3 z=2816; mode0 z=3825.
- x=3, y=5 → mode0 z=15; modes 1–3 z=0 (no dropped bit reaches column 8).
- Stall: stream 4 transactions, hold out_ready=0 for 5 cycles after first out_valid → z/out_valid stable, in_ready=0, no loss or duplication, order preserved on release.
- Reset asserted with 2 transactions in flight → next cycle out_valid=0, in_ready=1, counters 0; a new transaction yields a correct result 2 cycles after accept.
- STATS_EN, WIDTH=8, L=4, CNT_W=8:
  - Mode 1 0xFF×0xFF once → txn_count=1, err_sum=255 (saturated from 3825).
  - Build without STATS_EN → both outputs 0.

Source files
------------

// File: rtl/approx_mult_pkg.sv
// Shared types/constants for the approximate multiplier pipeline.
// Mode encoding, default sizes and a saturating-add helper.
package approx_mult_pkg;

  typedef enum logic [1:0] {
    MODE_EXACT = 2'd0,
    MODE_TRUNC = 2'd1,
    MODE_OR    = 2'd2,
    MODE_CNT   = 2'd3
  } mode_e;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_L     = 4;
  localparam int DEF_CNT_W = 32;

  // a + b, clamped to the all-ones value of a w-bit counter
  function automatic logic [63:0] sat_add(
    input logic [63:0] a,
    input logic [63:0] b,
    input int          w
  );
    logic [64:0] s;
    logic [64:0] m;
    s = {1'b0, a} + {1'b0, b};
    m = (65'd1 << w) - 65'd1;
    return (s > m) ? m[63:0] : s[63:0];
  endfunction

endpackage

// File: rtl/approx_pp_gen.sv
// Partial-product generator: P_hi plus per-column OR/popcount of
// dropped bits. Ports: x,y in; p_hi, col_or, col_cnt (cols W..2W-2) out.
module approx_pp_gen
  import approx_mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int L     = DEF_L,
  parameter int CW    = $clog2(L + 1)
) (
  input  logic [WIDTH-1:0]           x,
  input  logic [WIDTH-1:0]           y,
  output logic [2*WIDTH-1:0]         p_hi,
  output logic [WIDTH-2:0]           col_or,
  output logic [WIDTH-2:0][CW-1:0]   col_cnt
);

  localparam int PW = 2 * WIDTH;

  logic [PW-1:0] ye;
  logic [PW-1:0] xh;

  assign ye   = {{WIDTH{1'b0}}, y};
  assign xh   = {{(WIDTH + L){1'b0}}, x[WIDTH-1:L]};
  assign p_hi = (ye * xh) << L;

  // Column c here is weight c+WIDTH; row i lands there via y[c+WIDTH-i],
  // which only exists when i > c.
  for (genvar c = 0; c < WIDTH - 1; c++) begin : g_col
    logic [L-1:0] bits;
    for (genvar i = 0; i < L; i++) begin : g_row
      if (i > c) begin : g_on
        assign bits[i] = x[i] & y[c+WIDTH-i];
      end else begin : g_off
        assign bits[i] = 1'b0;
      end
    end
    assign col_or[c]  = |bits;
    assign col_cnt[c] = CW'($countones(bits));
  end

endmodule

// File: rtl/approx_mult_pipe.sv
// Two-stage pipelined approximate multiplier with valid/ready.
// Optional error statistics when STATS_EN is defined.
module approx_mult_pipe
  import approx_mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int L     = DEF_L,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  input  logic [1:0]         mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] z,
  output logic [CNT_W-1:0]   txn_count,
  output logic [CNT_W-1:0]   err_sum
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(L + 1);

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  logic [PW-1:0]               pp_hi;
  logic [WIDTH-2:0]            pp_or;
  logic [WIDTH-2:0][CW-1:0]    pp_cnt;

  approx_pp_gen #(
    .WIDTH (WIDTH),
    .L     (L),
    .CW    (CW)
  ) u_pp (
    .x       (x),
    .y       (y),
    .p_hi    (pp_hi),
    .col_or  (pp_or),
    .col_cnt (pp_cnt)
  );

  logic                        s1_valid;
  mode_e                       s1_mode;
  logic [WIDTH-1:0]            s1_x;
  logic [WIDTH-1:0]            s1_y;
  logic [PW-1:0]               s1_hi;
  logic [WIDTH-2:0]            s1_or;
  logic [WIDTH-2:0][CW-1:0]    s1_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_mode <= mode_e'(mode);
        s1_x    <= x;
        s1_y    <= y;
        s1_hi   <= pp_hi;
        s1_or   <= pp_or;
        s1_cnt  <= pp_cnt;
      end
    end
  end

  logic [PW-1:0] exact;
  logic [PW-1:0] or_term;
  logic [PW-1:0] z_nxt;
  logic [WIDTH-1:0][PW-1:0] cnt_acc;

  assign exact   = PW'(s1_x) * PW'(s1_y);
  // OR bit of column c already sits at weight c+WIDTH
  assign or_term = {1'b0, s1_or, {WIDTH{1'b0}}};

  assign cnt_acc[0] = '0;
  for (genvar c = 0; c < WIDTH - 1; c++) begin : g_cnt
    assign cnt_acc[c+1] = cnt_acc[c] + (PW'(s1_cnt[c]) << (c + WIDTH));
  end

  always_comb begin
    z_nxt = s1_hi;
    unique case (s1_mode)
      MODE_EXACT: z_nxt = exact;
      MODE_TRUNC: z_nxt = s1_hi;
      MODE_OR:    z_nxt = s1_hi + or_term;
      MODE_CNT:   z_nxt = s1_hi + cnt_acc[WIDTH-1];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      z         <= '0;
    end else if (adv) begin
      out_valid <= s1_valid;
      if (s1_valid) z <= z_nxt;
    end
  end

`ifdef STATS_EN
  logic [PW-1:0] s2_exact;
  logic [PW-1:0] err;

  assign err = s2_exact - z;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_exact  <= '0;
      txn_count <= '0;
      err_sum   <= '0;
    end else begin
      if (adv && s1_valid) s2_exact <= exact;
      if (out_valid && out_ready) begin
        txn_count <= CNT_W'(sat_add(64'(txn_count), 64'd1, CNT_W));
        err_sum   <= CNT_W'(sat_add(64'(err_sum), 64'(err), CNT_W));
      end
    end
  end
`else
  assign txn_count = '0;
  assign err_sum   = '0;
`endif

endmodule

// File: tb/tb_approx_mult_pipe.sv
// Directed bench for approx_mult_pipe (WIDTH=8, L=4, CNT_W=8).
// Expected products are hand-computed constants.
module tb_approx_mult_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  x;
  logic [7:0]  y;
  logic [1:0]  mode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] z;
  logic [7:0]  txn_count;
  logic [7:0]  err_sum;

  approx_mult_pipe #(
    .WIDTH (8),
    .L     (4),
    .CNT_W (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z         (z),
    .txn_count (txn_count),
    .err_sum   (err_sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [15:0] z;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // Output arrives one edge after the accept edge (2-cycle latency).
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious", 64'(out_valid), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("z", 64'(z), 64'(e.z));
        if (e.lat) check("lat", 64'(cyc - e.acc), 64'd1);
      end
    end
  end

  task automatic send(
    input logic [7:0]  a,
    input logic [7:0]  b,
    input logic [1:0]  m,
    input logic [15:0] ez,
    input bit          lat
  );
    int   n;
    bit   ok;
    exp_t e;
    x        = a;
    y        = b;
    mode     = m;
    in_valid = 1'b1;
    n        = 0;
    do begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      n++;
    end while (!ok && n < 50);
    if (!ok) begin
      check("send_timeout", 64'(in_ready), 64'd1);
    end else begin
      #1;
      e.z   = ez;
      e.acc = cyc;
      e.lat = lat;
      exp_q.push_back(e);
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cycles %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    x         = '0;
    y         = '0;
    mode      = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_z", 64'(z), 64'd0);
    check("rst_txn", 64'(txn_count), 64'd0);
    check("rst_err", 64'(err_sum), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // all four modes back-to-back on 0xFF x 0xFF
    send(8'hFF, 8'hFF, 2'd0, 16'd65025, 1'b1);
    send(8'hFF, 8'hFF, 2'd1, 16'd61200, 1'b1);
    send(8'hFF, 8'hFF, 2'd2, 16'd62992, 1'b1);
    send(8'hFF, 8'hFF, 2'd3, 16'd64016, 1'b1);
    idle();
    drain();

    // all of P_hi vanishes, only compensation survives
    send(8'h0F, 8'hFF, 2'd1, 16'd0,    1'b1);
    send(8'h0F, 8'hFF, 2'd2, 16'd1792, 1'b1);
    send(8'h0F, 8'hFF, 2'd3, 16'd2816, 1'b1);
    send(8'h0F, 8'hFF, 2'd0, 16'd3825, 1'b1);
    idle();
    drain();

    // no dropped bit reaches column 8
    send(8'd3, 8'd5, 2'd0, 16'd15, 1'b1);
    send(8'd3, 8'd5, 2'd1, 16'd0,  1'b1);
    send(8'd3, 8'd5, 2'd2, 16'd0,  1'b1);
    send(8'd3, 8'd5, 2'd3, 16'd0,  1'b1);
    idle();
    drain();

    // stall with second result parked in S2
    fork
      begin
        send(8'd2,   8'd3,   2'd0, 16'd6,     1'b0);
        send(8'h10,  8'h10,  2'd1, 16'd256,   1'b0);
        send(8'hAB,  8'hCD,  2'd0, 16'd35055, 1'b0);
        send(8'h0F,  8'hFF,  2'd3, 16'd2816,  1'b0);
        idle();
      end
      begin : stall_ctl
        int n;
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!out_valid && n < 20);
        check("stall_start", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          check("stall_z", 64'(z), 64'd256);
          check("stall_v", 64'(out_valid), 64'd1);
          check("stall_rdy", 64'(in_ready), 64'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // reset with two transactions in flight
    out_ready = 1'b0;
    send(8'd1, 8'd1, 2'd0, 16'd1, 1'b0);
    send(8'd2, 8'd2, 2'd0, 16'd4, 1'b0);
    idle();
    rst = 1'b1;
    @(negedge clk);
    check("inflight_v", 64'(out_valid), 64'd1);
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_v", 64'(out_valid), 64'd0);
    check("mid_rst_rdy", 64'(in_ready), 64'd1);
    check("mid_rst_txn", 64'(txn_count), 64'd0);
    check("mid_rst_err", 64'(err_sum), 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_v", 64'(out_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    send(8'h12, 8'h34, 2'd0, 16'd936, 1'b1);
    idle();
    drain();

    // statistics from a clean start
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    send(8'hFF, 8'hFF, 2'd1, 16'd61200, 1'b1);
    idle();
    drain();
    @(negedge clk);
`ifdef STATS_EN
    check("stat_txn", 64'(txn_count), 64'd1);
    check("stat_err", 64'(err_sum), 64'd255);
`else
    check("stat_txn", 64'(txn_count), 64'd0);
    check("stat_err", 64'(err_sum), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
